// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared
// memory port; master is the arbiter view, slave the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_stall_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o, if_stall_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_ack_o, dm_rdata_o, dm_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o, if_stall_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_ack_o, dm_rdata_o, dm_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM-stage accesses onto one memory.
// Define MEM_ARB_FAIRNESS_EN to bound IF starvation by STARVE_LIMIT.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("STARVE_LIMIT must be within 1..15");
  end

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic idle;
  logic starved;
  logic grant_dm;
  logic grant_if;
  logic capture;

  assign idle     = (state_q == IDLE);
  assign grant_dm = idle & bus.dm_req_i
                  & ~(bus.if_req_i & starved);
  assign grant_if = idle & bus.if_req_i & ~grant_dm;
  assign capture  = (state_q == BUSY) & bus.mem_ack_i;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign starved = (starve_q == LIMIT);

  // Counts DM wins over a waiting IF; any idle cycle without IF resets it.
  always_comb begin
    starve_d = starve_q;
    if (idle) begin
      if (grant_if || !bus.if_req_i) begin
        starve_d = '0;
      end else if (grant_dm) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY;
          owner_d     = OWN_DM;
          cmd_we_d    = bus.dm_we_i;
          cmd_addr_d  = bus.dm_addr_i;
          cmd_wdata_d = bus.dm_wdata_i;
        end else if (grant_if) begin
          state_d     = BUSY;
          owner_d     = OWN_IF;
          cmd_we_d    = 1'b0;
          cmd_addr_d  = bus.if_addr_i;
          cmd_wdata_d = '0;
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Write completions also refresh the owner's data register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture) begin
      if (owner_q == OWN_DM) begin
        dm_rdata_q <= bus.mem_rdata_i;
      end else begin
        if_rdata_q <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.mem_req_o   = (state_q == BUSY);
  assign bus.mem_we_o    = (state_q == BUSY) & cmd_we_q;
  assign bus.mem_addr_o  = cmd_addr_q;
  assign bus.mem_wdata_o = cmd_wdata_q;

  assign bus.if_ack_o    = (state_q == RESP) & (owner_q == OWN_IF);
  assign bus.dm_ack_o    = (state_q == RESP) & (owner_q == OWN_DM);
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i & ~bus.if_ack_o;
  assign bus.dm_stall_o  = bus.dm_req_i & ~bus.dm_ack_o;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch requester (IF stage, read-only) and the data-access requester (MEM stage, read/write) of the pipelined CPU. It serialises requests, holds each command stable on the memory port until the memory acknowledges, returns read data with a one-cycle acknowledge pulse, and drives per-requester stall outputs that freeze the PC, IF/ID and downstream pipeline registers while an access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive MEM grants tolerated while IF waits (legal 1..15; used only with fairness compiled in)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- if_req_i  in  1  IF read request (level)
- if_addr_i  in  ADDR_W  IF address
- if_ack_o  out  1  IF transaction complete (1-cycle pulse)
- if_rdata_o  out  DATA_W  IF read data, valid with if_ack_o
- if_stall_o  out  1  if_req_i & ~if_ack_o
- dm_req_i  in  1  MEM-stage request (level)
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_ack_o  out  1  data transaction complete (1-cycle pulse)
- dm_rdata_o  out  DATA_W  read data, valid with dm_ack_o
- dm_stall_o  out  1  dm_req_i & ~dm_ack_o
- mem_req_o  out  1  memory command valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion; read data valid this cycle
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY, RESP; owner register (IF/DM) valid in BUSY/RESP.
- IDLE: if any request, grant per priority, latch owner's we/addr/wdata into command registers (IF: we=0, wdata=0), go BUSY. No request: stay.
- Priority: DM over IF (DM is the older instruction).
- BUSY: mem_req_o=1, mem_we_o/addr/wdata from command registers, stable until mem_ack_i. On mem_ack_i: capture mem_rdata_i into owner's rdata register (also on writes), go RESP. Requester inputs ignored in BUSY.
- RESP: owner's ack_o=1 for exactly this cycle; mem_req_o=0; requests ignored; go IDLE.
- Requester protocol: hold req/addr/we/wdata stable until ack; in the cycle after ack either deassert or present a new transaction.
- Stall outputs combinational from req and ack as listed.
- if_rdata_o/dm_rdata_o hold last captured value between acks.
- mem_ack_i outside BUSY ignored.

## Timing
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_ack_o=0, dm_ack_o=0, rdata registers 0, starve counter 0.
- Req sampled in IDLE at cycle N -> mem_req_o=1 from N+1; mem_ack_i in cycle M (M>=N+1) -> ack_o in M+1 -> IDLE in M+2. Minimum 3 cycles per transaction; next grant earliest at M+2.
- Simultaneous if_req_i and dm_req_i in IDLE: DM granted; IF stays stalled, granted in the IDLE following DM's RESP if DM does not re-request (or per fairness).
- Reset asserted mid-transaction: mem_req_o drops asynchronously, transaction discarded without ack; requesters reissue after release.
- Memory latency unbounded; no timeout.

## Configuration
- Macro MEM_ARB_FAIRNESS_EN.
- Defined: 4-bit starve counter increments on each DM grant made while if_req_i=1; clears on IF grant or when if_req_i=0 in IDLE. When counter == STARVE_LIMIT and both request, IF is granted instead of DM.
- Undefined: strict DM priority; counter absent; STARVE_LIMIT unused; IF may starve indefinitely.

## Test plan
- Reset: rst_i high mid-BUSY -> mem_req_o=0 immediately, no ack; all outputs at reset values.
- Single IF read, addr 0x40, mem_ack_i 2 cycles after mem_req_o rises, mem_rdata_i=0xDEADBEEF -> mem_we_o=0, mem_addr_o=0x40, if_ack_o pulse next cycle with if_rdata_o=0xDEADBEEF, if_stall_o high until that cycle.
- DM write addr 0x100 data 0x12345678 with zero-wait memory -> mem_req_o one cycle, mem_we_o=1, dm_ack_o at grant+2, IDLE at grant+3.
- Simultaneous IF 0x0 and DM read 0x200 -> DM served first (dm_ack_o), then IF at 0x0; mem_addr_o never changes while mem_req_o=1.
- Fairness on, STARVE_LIMIT=2, DM requesting back-to-back, IF constantly requesting -> grants DM, DM, IF, DM, DM, IF; fairness off -> IF never granted while DM requests.
- mem_ack_i pulsed in IDLE/RESP -> no state change, no ack outputs.
